// File: rtl/ncl_word_boundary.sv
`default_nettype none
// ============================================================================
// Module   : ncl_word_boundary
// Purpose  : Boundary between the clocked domain and the clockless dual-rail
//            pipelined word adder. Encodes binary operands into DATA/NULL
//            wavefronts for the adder head, and decodes completed dual-rail
//            sum/carry wavefronts from the adder tail back to binary.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            in_valid/in_ready   - operand handshake (in_a, in_b, in_cin)
//            a_dr, b_dr, cin_dr  - registered dual-rail operands to the head
//            head_ko             - async head acknowledge (1 = wants DATA)
//            sum_dr, cout_dr     - dual-rail result from the tail
//            tail_ki             - acknowledge to the tail (1 = wants DATA)
//            out_valid/out_ready - result handshake (out_sum, out_cout)
// Revision : 1.0 - initial release
// ============================================================================
module ncl_word_boundary #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_cin,
   output logic [2*WIDTH-1:0]   a_dr,
   output logic [2*WIDTH-1:0]   b_dr,
   output logic [1:0]           cin_dr,
   input  logic                 head_ko,
   input  logic [2*WIDTH-1:0]   sum_dr,
   input  logic [1:0]           cout_dr,
   output logic                 tail_ki,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_sum,
   output logic                 out_cout
);

   localparam logic [1:0] I_NULL = 2'd0;
   localparam logic [1:0] I_IDLE = 2'd1;
   localparam logic [1:0] I_DATA = 2'd2;

   localparam logic [1:0] C_DATA = 2'd0;
   localparam logic [1:0] C_NULL = 2'd1;
   localparam logic [1:0] C_HOLD = 2'd2;

   // rail[1] carries the bit value, rail[0] its complement
   function automatic logic [2*WIDTH-1:0] dual_rail(input logic [WIDTH-1:0] v);
      logic [2*WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[2*i+1] = v[i];
         r[2*i]   = ~v[i];
      end
      return r;
   endfunction

   // ---------------------------------------------------------------- completion
   // A pair is DATA only when exactly one rail is high; a 2'b11 pair is
   // neither DATA nor NULL so the collector simply waits it out.
   logic [WIDTH:0]   pair_data;
   logic [WIDTH-1:0] sum_rail1;
   logic             tail_data;
   logic             tail_null;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_pair
         assign pair_data[gi] = sum_dr[2*gi] ^ sum_dr[2*gi+1];
         assign sum_rail1[gi] = sum_dr[2*gi+1];
      end
   endgenerate
   assign pair_data[WIDTH] = cout_dr[0] ^ cout_dr[1];
   assign tail_data = &pair_data;
   assign tail_null = ~|{sum_dr, cout_dr};

   // ------------------------------------------------------------ synchronizers
   logic [SYNC_STAGES-1:0] ko_sync, data_sync, null_sync;
   logic                   ko_s, data_s, null_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ko_sync   <= '0;
         data_sync <= '0;
         null_sync <= '0;
      end else begin
         ko_sync   <= {ko_sync[SYNC_STAGES-2:0],   head_ko};
         data_sync <= {data_sync[SYNC_STAGES-2:0], tail_data};
         null_sync <= {null_sync[SYNC_STAGES-2:0], tail_null};
      end
   end
   assign ko_s   = ko_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign null_s = null_sync[SYNC_STAGES-1];

   // ------------------------------------------------------------------ injector
   logic [1:0]         inj_state, inj_next;
   logic               in_ready_nxt;
   logic [2*WIDTH-1:0] a_dr_nxt, b_dr_nxt;
   logic [1:0]         cin_dr_nxt;
   logic               accept;

   assign accept = (inj_state == I_IDLE) && in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inj_state <= I_NULL;
         in_ready  <= 1'b0;
         a_dr      <= '0;
         b_dr      <= '0;
         cin_dr    <= 2'b00;
      end else begin
         inj_state <= inj_next;
         in_ready  <= in_ready_nxt;
         a_dr      <= a_dr_nxt;
         b_dr      <= b_dr_nxt;
         cin_dr    <= cin_dr_nxt;
      end
   end

   always_comb begin
      inj_next = inj_state;
      case (inj_state)
         I_NULL:  if (ko_s)   inj_next = I_IDLE;
         I_IDLE:  if (accept) inj_next = I_DATA;
         I_DATA:  if (!ko_s)  inj_next = I_NULL;
         default: inj_next = I_NULL;
      endcase
   end

   // Outputs are computed from the next state so every head-side output is a
   // plain flop and in_ready is already high on the first I_IDLE cycle.
   always_comb begin
      in_ready_nxt = (inj_next == I_IDLE);
      a_dr_nxt     = a_dr;
      b_dr_nxt     = b_dr;
      cin_dr_nxt   = cin_dr;
      if (inj_next == I_NULL) begin
         a_dr_nxt   = '0;
         b_dr_nxt   = '0;
         cin_dr_nxt = 2'b00;
      end else if (accept) begin
         a_dr_nxt   = dual_rail(in_a);
         b_dr_nxt   = dual_rail(in_b);
         cin_dr_nxt = {in_cin, ~in_cin};
      end
   end

   // ----------------------------------------------------------------- collector
   logic [1:0]       col_state, col_next;
   logic             tail_ki_nxt, out_valid_nxt, out_cout_nxt;
   logic [WIDTH-1:0] out_sum_nxt;
   logic             capture;

   assign capture = (col_state == C_DATA) && data_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_state <= C_DATA;
         tail_ki   <= 1'b1;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
      end else begin
         col_state <= col_next;
         tail_ki   <= tail_ki_nxt;
         out_valid <= out_valid_nxt;
         out_sum   <= out_sum_nxt;
         out_cout  <= out_cout_nxt;
      end
   end

   always_comb begin
      col_next = col_state;
      case (col_state)
         C_DATA:  if (data_s)     col_next = C_NULL;
         C_NULL:  if (null_s)     col_next = C_HOLD;
         C_HOLD:  if (!out_valid) col_next = C_DATA;  // never overwrite a result
         default: col_next = C_DATA;
      endcase
   end

   always_comb begin
      tail_ki_nxt   = (col_next == C_DATA);
      out_valid_nxt = out_valid;
      out_sum_nxt   = out_sum;
      out_cout_nxt  = out_cout;
      if (capture) begin
         out_valid_nxt = 1'b1;
         out_sum_nxt   = sum_rail1;
         out_cout_nxt  = cout_dr[1];
      end else if (out_valid && out_ready) begin
         out_valid_nxt = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ncl_word_boundary.sv
`default_nettype none
// ============================================================================
// Module   : tb_ncl_word_boundary
// Purpose  : Directed bench for ncl_word_boundary with a one-wavefront stub
//            standing in for the NCL adder pipeline (half-clock delay).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ncl_word_boundary;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid, in_ready, in_cin;
   logic [W-1:0]   in_a, in_b;
   logic [2*W-1:0] a_dr, b_dr, sum_dr;
   logic [1:0]     cin_dr, cout_dr, stub_cout;
   logic           head_ko, tail_ki;
   logic           out_valid, out_ready, out_cout;
   logic [W-1:0]   out_sum;
   logic           bad_cout;
   logic           full;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ncl_word_boundary #(.WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .a_dr(a_dr), .b_dr(b_dr), .cin_dr(cin_dr),
      .head_ko(head_ko), .sum_dr(sum_dr), .cout_dr(cout_dr),
      .tail_ki(tail_ki),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout)
   );

   function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
      logic [2*W-1:0] r;
      for (int i = 0; i < W; i++) begin
         r[2*i+1] = v[i];
         r[2*i]   = ~v[i];
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rail1(input logic [2*W-1:0] d);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = d[2*i+1];
      return r;
   endfunction

   function automatic logic all_data(input logic [2*W+2*W+1:0] d);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 2*W+1; i++) ok = ok & (d[2*i] ^ d[2*i+1]);
      return ok;
   endfunction

   // Stub pipeline: holds one wavefront, acknowledges the head, waits for tail.
   logic [2*W+2*W+1:0] head_bus;
   logic [W:0]         stub_res;
   assign head_bus = {a_dr, b_dr, cin_dr};
   assign stub_res = {1'b0, rail1(a_dr)} + {1'b0, rail1(b_dr)} + {{W{1'b0}}, cin_dr[1]};
   assign cout_dr  = bad_cout ? 2'b11 : stub_cout;

   always @(negedge clk or posedge reset) begin
      if (reset) begin
         full      <= 1'b0;
         head_ko   <= 1'b1;
         sum_dr    <= '0;
         stub_cout <= 2'b00;
      end else if (!full) begin
         if (all_data(head_bus) && tail_ki) begin
            sum_dr    <= enc(stub_res[W-1:0]);
            stub_cout <= {stub_res[W], ~stub_res[W]};
            full      <= 1'b1;
            head_ko   <= 1'b0;
         end
      end else if (head_bus == '0 && !tail_ki) begin
         sum_dr    <= '0;
         stub_cout <= 2'b00;
         full      <= 1'b0;
         head_ko   <= 1'b1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic ok;
      ok = 1'b0;
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      in_valid = 1'b0;
      check("accept_timeout", {63'd0, ok}, 64'd1);
   endtask

   task automatic wait_valid();
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("out_valid_timeout", {63'd0, ok}, 64'd1);
   endtask

   // Both FSMs back at rest: collector armed and injector ready.
   task automatic settle();
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (tail_ki && in_ready && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("settle_timeout", {63'd0, ok}, 64'd1);
   endtask

   task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic [W-1:0] es, input logic ec, input string tag);
      settle();
      out_ready = 1'b1;
      send(a, b, c);
      wait_valid();
      check({tag, "_sum"},  {56'd0, out_sum},  {56'd0, es});
      check({tag, "_cout"}, {63'd0, out_cout}, {63'd0, ec});
   endtask

   logic [W:0] q[$];
   logic [W:0] exp_res;
   logic       stable, acc;
   int         sent, got;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
      out_ready = 1'b0; bad_cout = 1'b0;

      // ---- reset values
      repeat (3) @(negedge clk);
      check("rst_in_ready",  {63'd0, in_ready},  64'd0);
      check("rst_a_dr",      {48'd0, a_dr},      64'd0);
      check("rst_b_dr",      {48'd0, b_dr},      64'd0);
      check("rst_cin_dr",    {62'd0, cin_dr},    64'd0);
      check("rst_tail_ki",   {63'd0, tail_ki},   64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_sum",   {56'd0, out_sum},   64'd0);
      check("rst_out_cout",  {63'd0, out_cout},  64'd0);
      reset = 1'b0;

      // ---- in_ready appears SYNC_STAGES+1 edges after head_ko is high
      repeat (2) @(negedge clk);
      check("ready_lat_early", {63'd0, in_ready}, 64'd0);
      @(negedge clk);
      check("ready_lat", {63'd0, in_ready}, 64'd1);

      // ---- first word: 0x3C + 0x0F + 1 = 0x4C
      send(8'h3C, 8'h0F, 1'b1);
      check("t1_a_dr",   {48'd0, a_dr},   {48'd0, enc(8'h3C)});
      check("t1_b_dr",   {48'd0, b_dr},   {48'd0, enc(8'h0F)});
      check("t1_cin_dr", {62'd0, cin_dr}, 64'd2);
      wait_valid();
      check("t1_sum",  {56'd0, out_sum},  64'h4C);
      check("t1_cout", {63'd0, out_cout}, 64'd0);
      check("t1_ki_low", {63'd0, tail_ki}, 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      check("t1_consumed", {63'd0, out_valid}, 64'd0);
      settle();
      check("t1_head_null", {30'd0, head_bus}, 64'd0);

      // ---- carry-out cases
      run_word(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2");
      run_word(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t3");

      // ---- back-pressure: 0x12+0x34 = 0x46, then 0x80+0x80 = 0x100
      settle();
      out_ready = 1'b0;
      send(8'h12, 8'h34, 1'b0);
      wait_valid();
      check("bp_first_sum", {56'd0, out_sum}, 64'h46);
      send(8'h80, 8'h80, 1'b0);
      stable = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!out_valid || out_sum !== 8'h46 || out_cout !== 1'b0 || tail_ki !== 1'b0)
            stable = 1'b0;
      end
      check("bp_hold_stable", {63'd0, stable}, 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_released", {63'd0, out_valid}, 64'd0);
      wait_valid();
      check("bp_second_sum",  {56'd0, out_sum},  64'h00);
      check("bp_second_cout", {63'd0, out_cout}, 64'd1);

      // ---- random stream with gaps on both sides
      settle();
      sent = 0; got = 0; acc = 1'b0;
      for (int cyc = 0; cyc < 6000 && got < 64; cyc++) begin
         @(negedge clk);
         if (!in_valid && sent < 64 && $urandom_range(0, 3) != 0) begin
            in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
            in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         acc = in_valid && in_ready;
         if (acc) begin
            q.push_back({1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin});
            sent++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("rnd_unexpected", 64'd1, 64'd0);
            end else begin
               exp_res = q.pop_front();
               check("rnd_result", {55'd0, out_cout, out_sum}, {55'd0, exp_res});
            end
            got++;
         end
         @(posedge clk);
         #1;
         if (acc) in_valid = 1'b0;
      end
      check("rnd_count", 64'(got), 64'd64);
      check("rnd_leftover", 64'(q.size()), 64'd0);

      // ---- illegal 2'b11 on cout stalls the collector: 0x01+0x02 = 0x03
      settle();
      out_ready = 1'b1;
      bad_cout = 1'b1;
      send(8'h01, 8'h02, 1'b0);
      repeat (30) @(negedge clk);
      check("bad_no_valid", {63'd0, out_valid}, 64'd0);
      check("bad_ki_high",  {63'd0, tail_ki},   64'd1);
      bad_cout = 1'b0;
      wait_valid();
      check("bad_recover_sum",  {56'd0, out_sum},  64'h03);
      check("bad_recover_cout", {63'd0, out_cout}, 64'd0);

      // ---- reset while injector holds DATA and a result is pending
      settle();
      out_ready = 1'b0;
      send(8'h55, 8'hAA, 1'b0);
      wait_valid();
      check("mid_sum", {56'd0, out_sum}, 64'hFF);
      send(8'h21, 8'h43, 1'b1);
      repeat (3) @(negedge clk);
      check("mid_data_held", {48'd0, a_dr}, {48'd0, enc(8'h21)});
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_rails",     {30'd0, head_bus}, 64'd0);
      check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("mid_rst_tail_ki",   {63'd0, tail_ki},   64'd1);
      check("mid_rst_in_ready",  {63'd0, in_ready},  64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ncl_word_boundary.md
# ncl_word_boundary

Clocked-to-NCL boundary stage for the pipelined full-word adder. It accepts binary operands on a synchronous valid/ready port and encodes them as dual-rail DATA/NULL wavefronts into the head of the NCL adder pipeline. It collects the dual-rail sum and carry from the tail of that pipeline, detects completeness, and decodes the result back onto a synchronous valid/ready port. Completion and acknowledge handshakes with the clockless pipeline are synchronized into the clock domain.

## Interface
- WIDTH, 8, operand/sum width in bits (≥1)
- SYNC_STAGES, 2, flops per asynchronous-input synchronizer (≥2)

- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operand word offered
- in_ready  out  1  operand accepted when in_valid & in_ready at posedge
- in_a, in_b  in  WIDTH  binary operands
- in_cin  in  1  binary carry-in
- a_dr, b_dr  out  2*WIDTH  dual-rail operands; bit i uses rails [2i+1:2i], rail 0 = logic 0, rail 1 = logic 1
- cin_dr  out  2  dual-rail carry-in
- head_ko  in  1  async acknowledge from the adder head: 1 = requests DATA, 0 = requests NULL
- sum_dr  in  2*WIDTH  dual-rail sum from the adder tail
- cout_dr  in  2  dual-rail carry-out
- tail_ki  out  1  acknowledge to the adder tail: 1 = requests DATA, 0 = requests NULL
- out_valid  out  1  decoded result present
- out_ready  in  1  result consumed when out_valid & out_ready at posedge
- out_sum  out  WIDTH  binary sum
- out_cout  out  1  binary carry-out

## Operation
- All outputs are registered. a_dr, b_dr, and cin_dr are driven from flops only, so they are glitch-free.
- head_ko, together with the tail completion flags tail_data and tail_null, each passes through a SYNC_STAGES synchronizer. Their synchronized versions are ko_s, data_s, and null_s.
- tail_data = every rail pair of sum_dr and cout_dr has exactly one rail high. tail_null = all rails low. Both are combinational ahead of the synchronizer.
- A pair with both rails high is illegal. It counts as neither DATA nor NULL, so the collector stalls.
- Injector FSM:
  - I_NULL: drive all rails 0, in_ready=0. When ko_s=1 → I_IDLE.
  - I_IDLE: in_ready=1. On accept, register the dual-rail encoding of in_a, in_b, in_cin (rail[v]=1 for bit value v) → I_DATA.
  - I_DATA: hold DATA, in_ready=0. When ko_s=0 → I_NULL, driving NULL on the next edge.
- Collector FSM:
  - C_DATA: tail_ki=1. When data_s=1, capture rail-1 of each sum_dr pair into out_sum and rail-1 of cout_dr into out_cout, set out_valid=1 and tail_ki=0 → C_NULL.
  - C_NULL: tail_ki=0. When null_s=1 → C_HOLD.
  - C_HOLD: tail_ki=0 until out_valid clears. Then tail_ki=1 → C_DATA.
- out_valid clears on the cycle after out_valid & out_ready. out_sum and out_cout hold until the next capture.
- Because the collector waits in C_HOLD for out_valid to clear before re-arming tail_ki, a second result cannot overwrite an unconsumed one. Back-pressure propagates through the NCL pipeline via tail_ki.
- Injector and collector are independent. Multiple wavefronts may be in flight inside the pipeline.
- Arithmetic correctness is a property of the pipeline. This block only encodes and decodes, with no width growth: out_cout carries bit WIDTH.

## Timing
- Reset values: in_ready=0, a_dr=b_dr=0, cin_dr=0 (NULL), tail_ki=1, out_valid=0, out_sum=0, out_cout=0. Both FSMs go to I_NULL / C_DATA and all synchronizer flops clear.
- Reset asserted mid-operation aborts both FSMs immediately and forces NULL on the head. A wavefront partly inside the pipeline is not recovered; the pipeline shares reset.
- Injector latency:
  - Accept at edge t → DATA on a_dr at t+1.
  - head_ko falling becomes visible SYNC_STAGES edges later, and NULL is driven one edge after that.
  - in_ready reasserts SYNC_STAGES+1 edges after head_ko rises.
- Collector latency: tail_data rising at time x → out_valid=1 at the (SYNC_STAGES+1)th edge after x, and tail_ki falls on that same edge.
- Minimum head-side period per word is 2·(SYNC_STAGES+1)+1 clocks plus pipeline delay.
- If in_valid is asserted while in I_NULL, in_ready stays 0 and the operands may change freely.
- out_ready asserted while out_valid=0 has no effect.

## Test plan
- Reset with a stub pipeline (sum = a+b+cin, 5 ns delay), then WIDTH=8, a=0x3C, b=0x0F, cin=1 → a_dr carries DATA at accept+1; out_sum=0x4C, out_cout=0, then tail_ki=1 and head rails return to NULL.
- a=0xFF, b=0x01, cin=0 → out_sum=0x00, out_cout=1. a=0xFF, b=0xFF, cin=1 → out_sum=0xFF, out_cout=1.
- Hold out_ready=0 for 40 cycles after the first result → out_valid stays 1, out_sum is stable, tail_ki stays 0 after NULL, and no second capture occurs. Releasing out_ready → the second result follows in order.
- Stream 64 random words with random in_valid/out_ready gaps → results match the golden model in order, with none lost or duplicated.
- Force cout_dr=2'b11 → no capture and out_valid stays 0. Restore a legal value → capture proceeds.
- Assert reset while in I_DATA with out_valid=1 → next cycle shows all rails 0, out_valid=0, tail_ki=1, in_ready=0.
